// File: rtl/instr_encoder_pkg.sv
// Shared kind codes, MIPS opcode/funct constants, FSM state type and field-packing helpers
// for the instruction encoder.
package instr_encoder_pkg;

  typedef enum logic [4:0] {
    K_ADDU  = 5'd0,
    K_SUBU  = 5'd1,
    K_AND   = 5'd2,
    K_OR    = 5'd3,
    K_SLT   = 5'd4,
    K_SLL   = 5'd5,
    K_SRL   = 5'd6,
    K_JR    = 5'd7,
    K_JALR  = 5'd8,
    K_ADDIU = 5'd9,
    K_ORI   = 5'd10,
    K_LW    = 5'd11,
    K_SW    = 5'd12,
    K_BEQ   = 5'd13,
    K_BNE   = 5'd14,
    K_J     = 5'd15
  } kind_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_JALR = 6'b001001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Command channel into the instruction encoder: valid/ready handshake plus mnemonic fields.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_kind;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [25:0] in_imm;
  logic        in_last;

  modport master (
    output in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_kind, in_rs, in_rt, in_rd, in_imm, in_last,
    output in_ready
  );
endinterface

// File: rtl/instr_encoder_pack.sv
// Combinational packer: mnemonic kind + register fields + immediate -> 32-bit MIPS word,
// with a flag for undefined kinds or I-type immediates that do not fit in 16 bits.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [4:0]  kind,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [25:0] imm,
  output logic [31:0] word,
  output logic        bad
);

  logic imm_hi_set;
  assign imm_hi_set = |imm[25:16];

  always_comb begin
    word = 32'h0000_0000;
    bad  = 1'b0;
    case (kind)
      K_ADDU:  word = rtype(rs, rt, rd, 5'd0, FN_ADDU);
      K_SUBU:  word = rtype(rs, rt, rd, 5'd0, FN_SUBU);
      K_AND:   word = rtype(rs, rt, rd, 5'd0, FN_AND);
      K_OR:    word = rtype(rs, rt, rd, 5'd0, FN_OR);
      K_SLT:   word = rtype(rs, rt, rd, 5'd0, FN_SLT);
      // Shifts take their amount from the immediate and never read rs.
      K_SLL:   word = rtype(5'd0, rt, rd, imm[4:0], FN_SLL);
      K_SRL:   word = rtype(5'd0, rt, rd, imm[4:0], FN_SRL);
      K_JR:    word = rtype(rs, 5'd0, 5'd0, 5'd0, FN_JR);
      K_JALR:  word = rtype(rs, rt, rd, 5'd0, FN_JALR);
      K_ADDIU: begin word = itype(OP_ADDIU, rs, rt, imm[15:0]); bad = imm_hi_set; end
      K_ORI:   begin word = itype(OP_ORI,   rs, rt, imm[15:0]); bad = imm_hi_set; end
      K_LW:    begin word = itype(OP_LW,    rs, rt, imm[15:0]); bad = imm_hi_set; end
      K_SW:    begin word = itype(OP_SW,    rs, rt, imm[15:0]); bad = imm_hi_set; end
      K_BEQ:   begin word = itype(OP_BEQ,   rs, rt, imm[15:0]); bad = imm_hi_set; end
      K_BNE:   begin word = itype(OP_BNE,   rs, rt, imm[15:0]); bad = imm_hi_set; end
      K_J:     word = {OP_J, imm};
      default: begin word = 32'h0000_0000; bad = 1'b1; end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streaming MIPS instruction encoder writing consecutive instruction-memory words.
// Define INSTR_ENC_CHECK_EN to drop malformed commands and raise the sticky err flag.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  instr_encoder_if.slave        cmd,
  input  logic                  mem_stall,
  output logic [3:0]            imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_din,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  err
);

  state_e                state_reg;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic                  out_valid_reg, out_valid_next;
  logic [ADDR_WIDTH-1:0] out_addr_reg, out_addr_next;
  logic [31:0]           out_data_reg, out_data_next;
  logic                  skid_full_reg, skid_full_next;
  logic [31:0]           skid_data_reg, skid_data_next;
  logic [ADDR_WIDTH:0]   count_reg;
  logic                  done_reg;
  logic                  err_reg;

  logic [31:0] pack_word;
  logic        pack_bad;
  logic        accept, drop, keep, write_fire, session_end;

  instr_pack u_pack (
    .kind (cmd.in_kind),
    .rs   (cmd.in_rs),
    .rt   (cmd.in_rt),
    .rd   (cmd.in_rd),
    .imm  (cmd.in_imm),
    .word (pack_word),
    .bad  (pack_bad)
  );

`ifdef INSTR_ENC_CHECK_EN
  assign drop = pack_bad;
`else
  logic unused_bad;
  assign unused_bad = pack_bad;
  assign drop       = 1'b0;
`endif

  assign cmd.in_ready = (state_reg == ST_RUN) && !skid_full_reg;
  assign accept       = cmd.in_valid && cmd.in_ready;
  assign keep         = accept && !drop;
  assign write_fire   = out_valid_reg && !mem_stall;
  assign session_end  = ((state_reg == ST_RUN) && accept && cmd.in_last) || (state_reg == ST_DRAIN);

  // Addresses are bound when a word enters the output register, so order is preserved
  // regardless of whether it passed through the skid.
  always_comb begin
    out_valid_next = out_valid_reg;
    out_addr_next  = out_addr_reg;
    out_data_next  = out_data_reg;
    skid_full_next = skid_full_reg;
    skid_data_next = skid_data_reg;
    addr_next      = addr_reg;
    if (!out_valid_reg || write_fire) begin
      if (skid_full_reg) begin
        out_valid_next = 1'b1;
        out_data_next  = skid_data_reg;
        out_addr_next  = addr_reg;
        addr_next      = addr_reg + 1'b1;
        skid_full_next = 1'b0;
      end else if (keep) begin
        out_valid_next = 1'b1;
        out_data_next  = pack_word;
        out_addr_next  = addr_reg;
        addr_next      = addr_reg + 1'b1;
      end else begin
        out_valid_next = 1'b0;
      end
    end else if (keep) begin
      skid_full_next = 1'b1;
      skid_data_next = pack_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      out_valid_reg <= 1'b0;
      out_addr_reg  <= '0;
      out_data_reg  <= '0;
      skid_full_reg <= 1'b0;
      skid_data_reg <= '0;
      count_reg     <= '0;
      done_reg      <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      out_valid_reg <= out_valid_next;
      out_addr_reg  <= out_addr_next;
      out_data_reg  <= out_data_next;
      skid_full_reg <= skid_full_next;
      skid_data_reg <= skid_data_next;
      addr_reg      <= addr_next;
      done_reg      <= 1'b0;
      err_reg       <= err_reg | (accept & drop);
      if (write_fire && (count_reg != '1))
        count_reg <= count_reg + 1'b1;

      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_RUN;
            addr_reg  <= base_addr;
            count_reg <= '0;
          end
        end
        ST_RUN, ST_DRAIN: begin
          // Look at next-cycle occupancy so done lands right after the final write.
          if (session_end) begin
            if (!out_valid_next && !skid_full_next) begin
              done_reg  <= 1'b1;
              state_reg <= ST_IDLE;
            end else begin
              state_reg <= ST_DRAIN;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign imem_we   = {4{out_valid_reg}};
  assign imem_addr = out_addr_reg;
  assign imem_din  = out_data_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign done      = done_reg;
  assign count     = count_reg;
  assign err       = err_reg;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: scoreboard of expected writes checked by a write monitor,
// plus status checks at session boundaries.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int AW = 12;
`ifdef INSTR_ENC_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic          mem_stall;
  logic [3:0]    imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_din;
  logic          busy;
  logic          done;
  logic [AW:0]   count;
  logic          err;

  instr_encoder_if cmd_bus ();

  instr_encoder #(.ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .cmd       (cmd_bus),
    .mem_stall (mem_stall),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_din  (imem_din),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t           sb[$];
  logic [AW-1:0] exp_addr;
  int            checks = 0;
  int            errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write monitor: every non-stalled write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (imem_we == 4'hF && !mem_stall) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write observed=%03h:%08h expected=none", imem_addr, imem_din);
      end
      if (sb.size() != 0) begin
        wr_t w;
        w = sb.pop_front();
        $display("write addr=%03h data=%08h", imem_addr, imem_din);
        check("write", {20'd0, imem_addr, imem_din}, {20'd0, w.addr, w.data});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input logic [31:0] word);
    wr_t w;
    w.addr = exp_addr;
    w.data = word;
    sb.push_back(w);
    exp_addr = exp_addr + 1'b1;
  endtask

  task automatic drive(input logic [4:0] k, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [25:0] imm, input logic last);
    cmd_bus.in_valid = 1'b1;
    cmd_bus.in_kind  = k;
    cmd_bus.in_rs    = rs;
    cmd_bus.in_rt    = rt;
    cmd_bus.in_rd    = rd;
    cmd_bus.in_imm   = imm;
    cmd_bus.in_last  = last;
  endtask

  task automatic send(input logic [4:0] k, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [25:0] imm, input logic last,
                      input logic [31:0] word, input logic kept);
    logic r;
    logic acc;
    acc = 1'b0;
    drive(k, rs, rt, rd, imm, last);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      r = cmd_bus.in_ready;
      @(posedge clk);
      #1;
      if (r) begin
        acc = 1'b1;
        break;
      end
    end
    cmd_bus.in_valid = 1'b0;
    cmd_bus.in_last  = 1'b0;
    check("accept", acc, 1'b1);
    $display("cmd kind=%0d word=%08h kept=%0d", k, word, kept);
    if (acc && kept) expect_write(word);
  endtask

  task automatic open_session(input logic [AW-1:0] b);
    base_addr = b;
    exp_addr  = b;
    start     = 1'b1;
    step();
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
  endtask

  task automatic wait_done(input string tag, input logic [AW:0] exp_count);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done"}, seen, 1'b1);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_count"}, count, exp_count);
    check({tag, "_drained"}, sb.size(), 0);
    step();
    check({tag, "_done_pulse"}, done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic seen_done;
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    mem_stall = 1'b0;
    exp_addr = '0;
    cmd_bus.in_valid = 1'b0;
    cmd_bus.in_kind = '0;
    cmd_bus.in_rs = '0;
    cmd_bus.in_rt = '0;
    cmd_bus.in_rd = '0;
    cmd_bus.in_imm = '0;
    cmd_bus.in_last = 1'b0;
    repeat (3) step();
    check("rst_we", imem_we, 4'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_count", count, 0);
    check("rst_err", err, 1'b0);
    check("rst_ready", cmd_bus.in_ready, 1'b0);
    rst = 1'b0;
    step();

    // Basic two-word program.
    open_session(12'h010);
    send(K_ADDU,  5'd1, 5'd2, 5'd3, 26'd0, 1'b0, 32'h00221821, 1'b1);
    send(K_ADDIU, 5'd0, 5'd8, 5'd0, 26'd5, 1'b1, 32'h24080005, 1'b1);
    wait_done("s1", 2);

    // Field-placement coverage across formats.
    open_session(12'h100);
    send(K_LW,  5'd29, 5'd9, 5'd0, 26'd4, 1'b0, 32'h8FA90004, 1'b1);
    send(K_SLL, 5'd0,  5'd3, 5'd2, 26'd4, 1'b0, 32'h00031100, 1'b1);
    send(K_SRL, 5'd7,  5'd3, 5'd2, 26'd4, 1'b0, 32'h00031102, 1'b1);
    send(K_JR,  5'd31, 5'd5, 5'd6, 26'd0, 1'b0, 32'h03E00008, 1'b1);
    send(K_J,   5'd0,  5'd0, 5'd0, 26'h0100000, 1'b1, 32'h08100000, 1'b1);
    wait_done("s2", 5);

    // Burst with a three-cycle memory stall filling the skid.
    open_session(12'h200);
    drive(K_OR, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0);
    expect_write(32'h00221825);
    step();
    mem_stall = 1'b1;
    drive(K_SUBU, 5'd4, 5'd5, 5'd6, 26'd0, 1'b0);
    expect_write(32'h00853023);
    step();
    check("stall_ready_drop", cmd_bus.in_ready, 1'b0);
    check("stall_we", imem_we, 4'hF);
    check("stall_hold_addr", imem_addr, 12'h200);
    check("stall_hold_din", imem_din, 32'h00221825);
    drive(K_AND, 5'd1, 5'd1, 5'd1, 26'd0, 1'b0);
    step();
    check("stall_ready_hold", cmd_bus.in_ready, 1'b0);
    step();
    mem_stall = 1'b0;
    send(K_AND, 5'd1, 5'd1, 5'd1, 26'd0, 1'b0, 32'h00210824, 1'b1);
    send(K_SLT, 5'd2, 5'd3, 5'd4, 26'd0, 1'b1, 32'h0043202A, 1'b1);
    wait_done("s3", 4);

    // Address wrap at the top of memory.
    open_session(12'hFFF);
    send(K_ORI, 5'd3, 5'd4, 5'd0, 26'h000BEEF, 1'b0, 32'h3464BEEF, 1'b1);
    send(K_BEQ, 5'd1, 5'd2, 5'd0, 26'h000FFFE, 1'b1, 32'h1022FFFE, 1'b1);
    wait_done("s4", 2);

    // Undefined kind.
    open_session(12'h030);
    send(5'd20, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0, 32'h00000000, !CHECK_EN);
    send(K_SW, 5'd29, 5'd31, 5'd0, 26'd8, 1'b1, 32'hAFBF0008, 1'b1);
    wait_done("s5", CHECK_EN ? 13'd1 : 13'd2);
    check("undef_err", err, CHECK_EN);

    // Reset with a stalled word and a full skid.
    open_session(12'h040);
    mem_stall = 1'b1;
    drive(K_ADDU, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0);
    step();
    drive(K_OR, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0);
    step();
    cmd_bus.in_valid = 1'b0;
    rst = 1'b1;
    step();
    check("mrst_we", imem_we, 4'h0);
    check("mrst_addr", imem_addr, 12'h000);
    check("mrst_din", imem_din, 32'h0);
    check("mrst_busy", busy, 1'b0);
    check("mrst_count", count, 0);
    check("mrst_err", err, 1'b0);
    check("mrst_ready", cmd_bus.in_ready, 1'b0);
    rst = 1'b0;
    mem_stall = 1'b0;
    seen_done = 1'b0;
    repeat (5) begin
      step();
      seen_done = seen_done | done;
    end
    check("mrst_no_done", seen_done, 1'b0);
    open_session(12'h050);
    send(K_ADDIU, 5'd0, 5'd8, 5'd0, 26'd5, 1'b1, 32'h24080005, 1'b1);
    wait_done("s6", 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming MIPS instruction encoder and instruction-memory writer. Accepts mnemonic-level instruction commands (kind, register fields, immediate) over a valid/ready handshake. It packs each command into a 32-bit MIPS word and writes the words to consecutive instruction-memory addresses starting from a programmable base. It is the producer side of the instruction word that the pipeline's decoder consumes, and is used by the on-chip program loader and by self-test sequences.

## Interface
- ADDR_WIDTH, 12, word-address width of instruction memory
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; opens a program session at base_addr
- base_addr  in  ADDR_WIDTH  first word address of the session
- in_valid  in  1  command valid
- in_ready  out  1  command accepted when in_valid & in_ready
- in_kind  in  5  mnemonic code (package list, 0–15 defined)
- in_rs, in_rt, in_rd  in  5 each  register fields
- in_imm  in  26  imm16 in [15:0], shamt in [4:0], jump target in [25:0]
- in_last  in  1  marks final command of session
- mem_stall  in  1  memory cannot take a write this cycle
- imem_we  out  4  byte write enable, 4'b1111 on write, else 0
- imem_addr  out  ADDR_WIDTH  write word address
- imem_din  out  32  encoded instruction
- busy  out  1  session open
- done  out  1  one-cycle pulse after the last word is written
- count  out  ADDR_WIDTH+1  words written this session, saturating
- err  out  1  sticky bad-command flag (only with the macro; otherwise tied 0)

## Operation
- Kinds and encodings:
  - ADDU, SUBU, AND, OR, SLT, SLL, SRL, JR, JALR → R-type {000000, rs, rt, rd, shamt, funct}. Funct values: 100001, 100011, 100100, 100101, 101010, 000000, 000010, 001000, 001001.
  - SLL/SRL: rs forced 0, shamt = in_imm[4:0]. All other R-types: shamt 0. JR: rt = rd = 0.
  - ADDIU, ORI, LW, SW, BEQ, BNE → {op, rs, rt, in_imm[15:0]}. Opcodes: 001001, 001101, 100011, 101011, 000100, 000101.
  - J → {000010, in_imm[25:0]}.
- Kinds 16–31 are undefined; handling is set by the macro.
- FSM states:
  - IDLE: in_ready=0; start → RUN, addr←base_addr, count←0.
  - RUN: accept commands; accepting one with in_last → DRAIN (in_ready=0 from the next cycle).
  - DRAIN: when the output stage and skid are both empty → pulse done, go to IDLE.
- start outside IDLE is ignored. in_valid in IDLE/DRAIN is ignored.
- Datapath:
  - One output register (imem_*) plus a one-entry skid buffer. in_ready = RUN & ~skid_full.
  - When mem_stall=1 the output register holds and the next accepted word goes to the skid. Words are written in order.
  - Each write increments addr modulo 2^ADDR_WIDTH (wraps silently) and count, saturating at all-ones.
- Reset (any time, including mid-session): state IDLE, pending words discarded, all outputs 0, err cleared.

## Timing
- Accept at edge N, no stall → imem_we=4'b1111 during cycle N+1 with that word. Throughput is 1 word/cycle.
- imem_we asserted while mem_stall=1 does not count as a write. The same addr/din are held until a cycle with mem_stall=0.
- done is high for exactly one cycle, the cycle after the final non-stalled write. busy falls together with done.
- Simultaneous stall and accept with the skid empty: the word goes to the skid and in_ready drops the next cycle.

## Configuration
- INSTR_ENC_CHECK_EN defined:
  - Undefined kinds, and I-type commands with in_imm[25:16]≠0, are accepted but dropped: no write, no count.
  - err is set sticky. in_last on a dropped command still ends the session.
- Not defined: undefined kinds encode as 32'h00000000 (nop) and are written and counted. imm upper bits are ignored. err=0.

## Structure
- A shared package holds the kind codes, opcode/funct constants, and the FSM state typedef.
- Sub-module instr_pack: purely combinational kind+fields → 32-bit word (plus bad flag). The top level holds the FSM, skid, counters and memory port.

## Test plan
- base_addr=0x010, start. ADDU rs1 rt2 rd3; ADDIU rs0 rt8 imm5 (last) → 0x00221821 @0x010, 0x24080005 @0x011, done, count=2.
- LW rt9 rs29 imm4 → 0x8FA90004. SLL rd2 rt3 shamt4 → 0x00031100. J target 0x0100000 → 0x08100000.
- mem_stall high for 3 cycles during a 4-word burst → in_ready drops after skid fill, words in order at consecutive addresses, no loss or duplicates.
- base_addr=0xFFF, 2 words → addresses 0xFFF then 0x000.
- in_kind=20 with the macro → no write, err=1, count unchanged. Without the macro → 0x00000000 written.
- rst asserted mid-burst with a stalled word pending → all outputs 0 next cycle, no done, new session starts cleanly.
